bus2st: RTL and testbench
=========================

// Module: bus2st
// PURPOSE
//   Parallel-bus-to-Avalon-ST serializer; the stage directly upstream of the turbo decoder
//   (memory -> bus2st -> TurboDecoder -> st2bus -> output). Accepts BUS-wide words from the
//   memory side and emits ST-bit symbols, framed with sop/eop, ST_PER_TURBO_PKT symbols per
//   turbo packet. Single clock domain; a two-word buffer sustains one symbol per cycle.
// PARAMETERS
//   BUS              534  bus word width; [ST_PER_BUS-1:0] payload, [BUS-1:ST_PER_BUS] sideband
//   ST_PER_BUS       512  payload bits per bus word
//   NUM_ST_PER_BUS   64   symbols per bus word (= ST_PER_BUS/ST)
//   ST_PER_TURBO_PKT 128  symbols per turbo packet (>=1; need not be a multiple of NUM_ST_PER_BUS)
//   ST               8    symbol width
// PORTS
//   clk_400     in   1    clock
//   rst_n       in   1    reset, synchronous, active-low
//   bus_data    in   BUS  bus word; bit ST_PER_BUS = packet error flag, other sideband bits ignored
//   bus_en      in   1    bus_data valid; word accepted when bus_en && bus_ready
//   bus_ready   out  1    buffer can take a word this cycle (registered)
//   st_ready    in   1    decoder accepts symbol (Avalon-ST, readyLatency 0)
//   st_data     out  ST   symbol
//   st_valid    out  1    st_data valid; beat transfers when st_valid && st_ready
//   st_sop      out  1    first symbol of turbo packet
//   st_eop      out  1    last symbol of turbo packet
//   st_error    out  1    packet error, asserted only on the eop beat
// BEHAVIOUR
//   Reset: rst_n low at a rising edge -> all outputs 0 (bus_ready 0), buffers empty, counters 0.
//     bus_ready rises at the first edge with rst_n high.
//   Storage: shift register SR (active word) + holding register HR; each has a valid bit.
//     bus_ready is registered as next-cycle !HR_valid.
//   Symbol order: LSB first; symbol k of a word = payload[k*ST +: ST].
//   Counters: sym_idx 0..NUM_ST_PER_BUS-1 (in word), pkt_idx 0..ST_PER_TURBO_PKT-1 (in packet),
//     widths $clog2. Both advance only on a beat.
//   Framing: st_sop = (pkt_idx==0); st_eop = (pkt_idx==ST_PER_TURBO_PKT-1).
//     After eop, pkt_idx wraps to 0.
//   Word end: a beat with sym_idx==NUM_ST_PER_BUS-1 OR st_eop retires SR. Remaining symbols in
//     that word are discarded; the next packet always starts at symbol 0 of a fresh word.
//     sym_idx -> 0.
//   Error: per-word error bit is captured with the word. st_error = eop && OR of error bits of
//     all words of the current packet (sticky flag, cleared after the eop beat).
//   States: EMPTY (SR invalid, st_valid=0) / STREAM (SR valid, st_valid=1).
//     EMPTY->STREAM: word accepted -> loads SR directly. st_valid=1 the cycle after the accept
//       edge (latency 1).
//     STREAM, SR retiring on a beat: HR valid -> HR moves to SR the same edge (no bubble).
//       Else, if a word is accepted the same cycle, it loads SR directly. Else -> EMPTY.
//     STREAM, not retiring: an accepted word goes to HR.
//   Simultaneous accept + retire with HR valid cannot occur (bus_ready=0 then).
//   Avalon-ST: while st_valid && !st_ready, st_data/sop/eop/error are held stable; st_valid is
//     never withdrawn without a beat.
//   Output regs update only on a beat or on an SR load from EMPTY.
//   Throughput: with st_ready=1 and a word offered each time bus_ready=1, st_valid stays high
//     continuously.
// TESTING
//   T1 reset: drive garbage, rst_n=0 3 cycles -> all outputs 0. Release -> bus_ready=1 next edge,
//      st_valid=0.
//   T2 single packet, defaults: 2 words, symbol k = k[7:0], st_ready=1 -> 128 back-to-back beats,
//      data 0..127, sop on beat 0 only, eop on beat 127 only, first st_valid 1 cycle after
//      first accept.
//   T3 backpressure: 8 packets, st_ready random 50% -> data/sop/eop stable while stalled,
//      bus_ready=0 while HR full, no symbol lost or duplicated vs. scoreboard.
//   T4 partial word, ST_PER_TURBO_PKT=100: word1 symbols 36..63 = 0xEE -> never output.
//      Next packet's sop carries word2 symbol 0.
//   T5 error: bit 512 set on first word of packet 2 only -> st_error=1 on packet 2 eop beat,
//      0 on every other beat.
//   T6 reset mid-packet: rst_n=0 after beat 50 with HR full -> outputs 0 next edge. Next packet
//      starts with sop, data from first new word, no stale symbols.

Source files
------------

// File: rtl/bus2st_if.sv
// Bundle of the memory-side bus handshake and the Avalon-ST symbol stream of bus2st.
// master = environment side (memory + decoder), slave = the serializer itself.
interface bus2st_if #(
  parameter int BUS = 534,
  parameter int ST  = 8
);
  logic [BUS-1:0] bus_data;
  logic           bus_en;
  logic           bus_ready;
  logic           st_ready;
  logic [ST-1:0]  st_data;
  logic           st_valid;
  logic           st_sop;
  logic           st_eop;
  logic           st_error;

  modport master (
    output bus_data, bus_en, st_ready,
    input  bus_ready, st_data, st_valid, st_sop, st_eop, st_error
  );

  modport slave (
    input  bus_data, bus_en, st_ready,
    output bus_ready, st_data, st_valid, st_sop, st_eop, st_error
  );
endinterface

// File: rtl/bus2st.sv
// Serializes bus words into ST-bit Avalon-ST symbols framed into turbo packets.
// A shift register streams the active word while a holding register absorbs the next one.
module bus2st #(
  parameter int BUS              = 534,
  parameter int ST_PER_BUS       = 512,
  parameter int NUM_ST_PER_BUS   = 64,
  parameter int ST_PER_TURBO_PKT = 128,
  parameter int ST               = 8
) (
  input  logic     clk_400,
  input  logic     rst_n,
  bus2st_if.slave  bus_if
);

  localparam int SYM_W = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
  localparam int PKT_W = (ST_PER_TURBO_PKT > 1) ? $clog2(ST_PER_TURBO_PKT) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_ST_PER_BUS - 1);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(ST_PER_TURBO_PKT - 1);

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ST_PER_BUS-1:0] srData_q, srData_d;
  logic [ST_PER_BUS-1:0] hrData_q, hrData_d;
  logic                  srErr_q, srErr_d;
  logic                  hrErr_q, hrErr_d;
  logic                  hrValid_q, hrValid_d;
  logic [SYM_W-1:0]      symIdx_q, symIdx_d;
  logic [PKT_W-1:0]      pktIdx_q, pktIdx_d;
  logic                  errSticky_q, errSticky_d;
  logic                  busReady_q, busReady_d;

  logic                  stValid;
  logic                  isEop;
  logic                  beat;
  logic                  retire;
  logic                  accept;
  logic [ST_PER_BUS-1:0] inPayload;
  logic                  inErr;
  logic                  unused_sideband;

  assign inPayload = bus_if.bus_data[ST_PER_BUS-1:0];
  assign inErr     = bus_if.bus_data[ST_PER_BUS];

  // Sideband bits other than the error flag carry nothing for this stage.
  generate
    if (BUS > ST_PER_BUS + 1) begin : gSideband
      assign unused_sideband = ^bus_if.bus_data[BUS-1:ST_PER_BUS+1];
    end else begin : gNoSideband
      assign unused_sideband = 1'b0;
    end
  endgenerate

  assign stValid = (state_q == STREAM);
  assign isEop   = stValid && (pktIdx_q == PKT_LAST);
  assign beat    = stValid && bus_if.st_ready;
  assign retire  = beat && ((symIdx_q == SYM_LAST) || (pktIdx_q == PKT_LAST));
  assign accept  = bus_if.bus_en && busReady_q;

  assign bus_if.bus_ready = busReady_q;
  assign bus_if.st_valid  = stValid;
  assign bus_if.st_data   = srData_q[ST-1:0];
  assign bus_if.st_sop    = stValid && (pktIdx_q == '0);
  assign bus_if.st_eop    = isEop;
  assign bus_if.st_error  = isEop && (errSticky_q || srErr_q);

  always_comb begin
    state_d     = state_q;
    srData_d    = srData_q;
    srErr_d     = srErr_q;
    hrData_d    = hrData_q;
    hrErr_d     = hrErr_q;
    hrValid_d   = hrValid_q;
    symIdx_d    = symIdx_q;
    pktIdx_d    = pktIdx_q;
    errSticky_d = errSticky_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          srData_d = inPayload;
          srErr_d  = inErr;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (retire) begin
          // A retiring word is replaced from HR first; a fresh accept can only land when HR is empty.
          if (hrValid_q) begin
            srData_d  = hrData_q;
            srErr_d   = hrErr_q;
            hrValid_d = 1'b0;
          end else if (accept) begin
            srData_d = inPayload;
            srErr_d  = inErr;
          end else begin
            state_d = EMPTY;
          end
        end else begin
          if (beat) begin
            srData_d = srData_q >> ST;
          end
          if (accept) begin
            hrData_d  = inPayload;
            hrErr_d   = inErr;
            hrValid_d = 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    if (beat) begin
      symIdx_d = retire ? '0 : symIdx_q + 1'b1;
      pktIdx_d = isEop ? '0 : pktIdx_q + 1'b1;
      if (isEop) begin
        errSticky_d = 1'b0;
      end else if (retire) begin
        errSticky_d = errSticky_q || srErr_q;
      end
    end

    busReady_d = !hrValid_d;
  end

  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      srData_q    <= '0;
      srErr_q     <= 1'b0;
      hrData_q    <= '0;
      hrErr_q     <= 1'b0;
      hrValid_q   <= 1'b0;
      symIdx_q    <= '0;
      pktIdx_q    <= '0;
      errSticky_q <= 1'b0;
      busReady_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      srData_q    <= srData_d;
      srErr_q     <= srErr_d;
      hrData_q    <= hrData_d;
      hrErr_q     <= hrErr_d;
      hrValid_q   <= hrValid_d;
      symIdx_q    <= symIdx_d;
      pktIdx_q    <= pktIdx_d;
      errSticky_q <= errSticky_d;
      busReady_q  <= busReady_d;
    end
  end

endmodule

// File: tb/tb_bus2st.sv
// Randomized bench for bus2st: a word-queue model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed symbol values.
module tb_bus2st;

  localparam int BUS  = 534;
  localparam int SPB  = 512;
  localparam int NSYM = 64;
  localparam int PKT  = 100;
  localparam int ST   = 8;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  bus2st_if #(.BUS(BUS), .ST(ST)) busIf ();

  bus2st #(
    .BUS(BUS), .ST_PER_BUS(SPB), .NUM_ST_PER_BUS(NSYM),
    .ST_PER_TURBO_PKT(PKT), .ST(ST)
  ) dut (
    .clk_400(clk),
    .rst_n  (rstN),
    .bus_if (busIf.slave)
  );

  int checks    = 0;
  int errors    = 0;
  int readyPct  = 100;
  int cycle     = 0;

  // Model: words accepted but not yet fully consumed, plus position inside word and packet.
  logic [SPB-1:0] mqData[$];
  bit             mqErr[$];
  int             mSym = 0;
  int             mPkt = 0;
  bit             mAcc = 0;
  bit             modelKnown = 0;
  bit             modelInReset = 0;
  bit             readyArmed = 0;

  logic [7:0] logData[$];
  bit         logSop[$];
  bit         logEop[$];
  bit         logErr[$];
  int         logCyc[$];

  bit             prevStall = 0;
  logic [7:0]     prevData;
  logic           prevSop, prevEop, prevErr;
  logic [SPB-1:0] curWord;
  logic [7:0]     expData;
  bit             expValid, expReady, expEop, expErr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [BUS-1:0] makeWord(input int base, input bit err,
                                                input int tailStart, input logic [7:0] tailVal);
    logic [BUS-1:0] w;
    w = '0;
    for (int k = 0; k < NSYM; k++) begin
      w[k*ST +: ST] = (k < tailStart) ? 8'(base + k) : tailVal;
    end
    for (int b = SPB + 1; b < BUS; b++) w[b] = 1'($urandom_range(0, 1));
    w[SPB] = err;
    return w;
  endfunction

  function automatic logic [BUS-1:0] randWord(input bit err);
    logic [BUS-1:0] w;
    for (int b = 0; b < BUS; b++) w[b] = 1'($urandom_range(0, 1));
    w[SPB] = err;
    return w;
  endfunction

  always @(posedge clk) cycle++;

  initial begin
    busIf.st_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      busIf.st_ready = (readyPct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < readyPct);
    end
  end

  always @(negedge clk) begin
    expValid = mqData.size() > 0;
    expReady = readyArmed && (mqData.size() < 2);
    expEop   = expValid && (mPkt == PKT - 1);
    expErr   = 1'b0;
    expData  = '0;
    if (expValid) begin
      curWord = mqData[0];
      expData = curWord[mSym*ST +: ST];
      expErr  = expEop && (mAcc || mqErr[0]);
    end

    if (modelKnown) begin
      if (modelInReset) begin
        checkOutput("rst_valid", 32'(busIf.st_valid), 32'd0);
        checkOutput("rst_ready", 32'(busIf.bus_ready), 32'd0);
        checkOutput("rst_data",  32'(busIf.st_data), 32'd0);
        checkOutput("rst_sop",   32'(busIf.st_sop), 32'd0);
        checkOutput("rst_eop",   32'(busIf.st_eop), 32'd0);
        checkOutput("rst_error", 32'(busIf.st_error), 32'd0);
      end else begin
        checkOutput("st_valid",  32'(busIf.st_valid), 32'(expValid));
        checkOutput("bus_ready", 32'(busIf.bus_ready), 32'(expReady));
        if (expValid) begin
          checkOutput("st_data",  32'(busIf.st_data), 32'(expData));
          checkOutput("st_sop",   32'(busIf.st_sop), 32'(mPkt == 0));
          checkOutput("st_eop",   32'(busIf.st_eop), 32'(expEop));
          checkOutput("st_error", 32'(busIf.st_error), 32'(expErr));
        end
        if (prevStall) begin
          checkOutput("hold_valid", 32'(busIf.st_valid), 32'd1);
          checkOutput("hold_data",  32'(busIf.st_data), 32'(prevData));
          checkOutput("hold_sop",   32'(busIf.st_sop), 32'(prevSop));
          checkOutput("hold_eop",   32'(busIf.st_eop), 32'(prevEop));
          checkOutput("hold_error", 32'(busIf.st_error), 32'(prevErr));
        end
      end
    end

    prevStall = modelKnown && !modelInReset && rstN && busIf.st_valid && !busIf.st_ready;
    prevData  = busIf.st_data;
    prevSop   = busIf.st_sop;
    prevEop   = busIf.st_eop;
    prevErr   = busIf.st_error;

    if (rstN && busIf.st_valid && busIf.st_ready) begin
      logData.push_back(busIf.st_data);
      logSop.push_back(busIf.st_sop);
      logEop.push_back(busIf.st_eop);
      logErr.push_back(busIf.st_error);
      logCyc.push_back(cycle);
    end

    // Advance the model to the state it must hold after the coming rising edge.
    if (!rstN) begin
      mqData.delete();
      mqErr.delete();
      mSym = 0;
      mPkt = 0;
      mAcc = 0;
      modelInReset = 1;
      readyArmed = 0;
      modelKnown = 1;
    end else if (modelKnown) begin
      if (expValid && busIf.st_ready) begin
        mPkt = expEop ? 0 : mPkt + 1;
        mSym++;
        if (mSym == NSYM || expEop) begin
          mAcc = mAcc || mqErr[0];
          void'(mqData.pop_front());
          void'(mqErr.pop_front());
          mSym = 0;
        end
        if (expEop) mAcc = 0;
      end
      if (busIf.bus_en && expReady) begin
        mqData.push_back(busIf.bus_data[SPB-1:0]);
        mqErr.push_back(busIf.bus_data[SPB]);
      end
      modelInReset = 0;
      readyArmed = 1;
    end
  end

  task automatic applyStimulus(input logic [BUS-1:0] w);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    busIf.bus_data = w;
    busIf.bus_en = 1'b1;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (busIf.bus_ready === 1'b1) done = 1;
      @(posedge clk);
      #1;
    end
    busIf.bus_en = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (mqData.size() > 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mqData.size() > 0) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic clearLog();
    logData.delete();
    logSop.delete();
    logEop.delete();
    logErr.delete();
    logCyc.delete();
  endtask

  task automatic summarizeLog(output int nSop, output int nEop, output int nErr,
                              output int lastErr, output int nEE);
    nSop = 0; nEop = 0; nErr = 0; lastErr = -1; nEE = 0;
    for (int i = 0; i < logData.size(); i++) begin
      if (logSop[i]) nSop++;
      if (logEop[i]) nEop++;
      if (logErr[i]) begin nErr++; lastErr = i; end
      if (logData[i] == 8'hEE) nEE++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nSop, nEop, nErr, lastErr, nEE, seqBad, n;

    // T1: reset with garbage on the bus
    busIf.bus_en = 1'b1;
    busIf.bus_data = randWord(1'b1);
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); #1;
    checkOutput("t1_valid", 32'(busIf.st_valid), 32'd0);
    checkOutput("t1_ready", 32'(busIf.bus_ready), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    busIf.bus_en = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    checkOutput("t1_ready_rise", 32'(busIf.bus_ready), 32'd1);
    checkOutput("t1_valid_low", 32'(busIf.st_valid), 32'd0);
    @(posedge clk); #1;

    // T2: one packet, symbol k = k, full readiness
    readyPct = 100;
    clearLog();
    applyStimulus(makeWord(0, 1'b0, NSYM, 8'h00));
    @(negedge clk); #1;
    checkOutput("t2_latency", 32'(busIf.st_valid), 32'd1);
    @(posedge clk); #1;
    applyStimulus(makeWord(64, 1'b0, NSYM, 8'h00));
    waitDrain();
    summarizeLog(nSop, nEop, nErr, lastErr, nEE);
    checkOutput("t2_beats", 32'(logData.size()), 32'd100);
    checkOutput("t2_sops", 32'(nSop), 32'd1);
    checkOutput("t2_eops", 32'(nEop), 32'd1);
    if (logData.size() == 100) begin
      seqBad = 0;
      for (int i = 0; i < 100; i++) if (logData[i] != 8'(i)) seqBad++;
      checkOutput("t2_sequence", 32'(seqBad), 32'd0);
      checkOutput("t2_first", 32'(logData[0]), 32'h00);
      checkOutput("t2_last", 32'(logData[99]), 32'h63);
      checkOutput("t2_sop0", 32'(logSop[0]), 32'd1);
      checkOutput("t2_eop99", 32'(logEop[99]), 32'd1);
      checkOutput("t2_contiguous", 32'(logCyc[99] - logCyc[0]), 32'd99);
    end

    // T3: eight packets of random words under random backpressure
    readyPct = 50;
    clearLog();
    for (int w = 0; w < 16; w++) applyStimulus(randWord($urandom_range(0, 3) == 0));
    waitDrain();
    summarizeLog(nSop, nEop, nErr, lastErr, nEE);
    checkOutput("t3_beats", 32'(logData.size()), 32'd800);
    checkOutput("t3_sops", 32'(nSop), 32'd8);
    checkOutput("t3_eops", 32'(nEop), 32'd8);

    // T4: discarded tail of the partial word never appears
    readyPct = 70;
    clearLog();
    applyStimulus(makeWord(8'h10, 1'b0, NSYM, 8'h00));
    applyStimulus(makeWord(8'h50, 1'b0, 36, 8'hEE));
    applyStimulus(makeWord(8'h80, 1'b0, NSYM, 8'h00));
    applyStimulus(makeWord(8'hC0, 1'b0, 36, 8'h00));
    waitDrain();
    summarizeLog(nSop, nEop, nErr, lastErr, nEE);
    checkOutput("t4_beats", 32'(logData.size()), 32'd200);
    checkOutput("t4_no_ee", 32'(nEE), 32'd0);
    if (logData.size() == 200) begin
      checkOutput("t4_last_pkt1", 32'(logData[99]), 32'h73);
      checkOutput("t4_sop_pkt2", 32'(logSop[100]), 32'd1);
      checkOutput("t4_data_pkt2", 32'(logData[100]), 32'h80);
      checkOutput("t4_word3_sym0", 32'(logData[164]), 32'hC0);
    end

    // T5: error flag on the first word of the second packet
    readyPct = 60;
    clearLog();
    for (int w = 0; w < 6; w++) applyStimulus(makeWord(w * 16, w == 2, NSYM, 8'h00));
    waitDrain();
    summarizeLog(nSop, nEop, nErr, lastErr, nEE);
    checkOutput("t5_beats", 32'(logData.size()), 32'd300);
    checkOutput("t5_err_count", 32'(nErr), 32'd1);
    checkOutput("t5_err_index", 32'(lastErr), 32'd199);

    // T6: reset in the middle of a packet with HR occupied
    readyPct = 100;
    clearLog();
    applyStimulus(makeWord(8'h20, 1'b0, NSYM, 8'h00));
    applyStimulus(makeWord(8'h60, 1'b0, NSYM, 8'h00));
    n = 0;
    while (logData.size() < 51 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t6_reached_beat50", 32'(logData.size() >= 51), 32'd1);
    checkOutput("t6_hr_full", 32'(busIf.bus_ready), 32'd0);
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    checkOutput("t6_valid_zero", 32'(busIf.st_valid), 32'd0);
    checkOutput("t6_ready_zero", 32'(busIf.bus_ready), 32'd0);
    checkOutput("t6_sop_zero", 32'(busIf.st_sop), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    clearLog();
    applyStimulus(makeWord(8'hA0, 1'b0, NSYM, 8'h00));
    applyStimulus(makeWord(8'h30, 1'b0, NSYM, 8'h00));
    waitDrain();
    checkOutput("t6_beats", 32'(logData.size()), 32'd100);
    if (logData.size() == 100) begin
      checkOutput("t6_first_data", 32'(logData[0]), 32'hA0);
      checkOutput("t6_first_sop", 32'(logSop[0]), 32'd1);
      checkOutput("t6_word2_data", 32'(logData[64]), 32'h30);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
